// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse-to-ASCII translator.
package morse_pkg;

  localparam int MORSE_LEN_W = 3;
  localparam int MORSE_PAT_W = 6;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  typedef enum logic {
    ACCUM = 1'b0,
    SPACE = 1'b1
  } morse_state_e;

  // pat holds the symbols right-aligned, first symbol in the highest used bit
  typedef struct packed {
    logic [MORSE_LEN_W-1:0] len;
    logic [MORSE_PAT_W-1:0] pat;
  } morse_key_t;

  function automatic logic [MORSE_LEN_W-1:0] len_inc(input logic [MORSE_LEN_W-1:0] l);
    return (l == '1) ? l : l + MORSE_LEN_W'(1);
  endfunction

endpackage

// File: rtl/morse_to_ascii_if.sv
// Symbol pulses in, buffered ASCII characters out through a valid/ready handshake.
interface morse_to_ascii_if;

  logic       dot;
  logic       dash;
  logic       lg;
  logic       wg;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       overflow;

  modport master (
    output dot, dash, lg, wg, ascii_ready,
    input  ascii, ascii_valid, overflow
  );

  modport slave (
    input  dot, dash, lg, wg, ascii_ready,
    output ascii, ascii_valid, overflow
  );

endinterface

// File: rtl/morse_to_ascii_lut.sv
// Combinational Morse pattern to ASCII table (dot=0, dash=1).
// Digits and . , ? are decoded only when MORSE_DIGITS_EN is defined.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 6
) (
  input  morse_key_t  key,
  output logic [7:0]  ascii
);

  always_comb begin
    ascii = ASCII_UNKNOWN;
    if (key.len != '0 && int'(key.len) <= MAX_SYMBOLS) begin
      case (key)
        {3'd1, 6'd0}:  ascii = 8'h45; // E
        {3'd1, 6'd1}:  ascii = 8'h54; // T
        {3'd2, 6'd0}:  ascii = 8'h49; // I
        {3'd2, 6'd1}:  ascii = 8'h41; // A
        {3'd2, 6'd2}:  ascii = 8'h4E; // N
        {3'd2, 6'd3}:  ascii = 8'h4D; // M
        {3'd3, 6'd0}:  ascii = 8'h53; // S
        {3'd3, 6'd1}:  ascii = 8'h55; // U
        {3'd3, 6'd2}:  ascii = 8'h52; // R
        {3'd3, 6'd3}:  ascii = 8'h57; // W
        {3'd3, 6'd4}:  ascii = 8'h44; // D
        {3'd3, 6'd5}:  ascii = 8'h4B; // K
        {3'd3, 6'd6}:  ascii = 8'h47; // G
        {3'd3, 6'd7}:  ascii = 8'h4F; // O
        {3'd4, 6'd0}:  ascii = 8'h48; // H
        {3'd4, 6'd1}:  ascii = 8'h56; // V
        {3'd4, 6'd2}:  ascii = 8'h46; // F
        {3'd4, 6'd4}:  ascii = 8'h4C; // L
        {3'd4, 6'd6}:  ascii = 8'h50; // P
        {3'd4, 6'd7}:  ascii = 8'h4A; // J
        {3'd4, 6'd8}:  ascii = 8'h42; // B
        {3'd4, 6'd9}:  ascii = 8'h58; // X
        {3'd4, 6'd10}: ascii = 8'h43; // C
        {3'd4, 6'd11}: ascii = 8'h59; // Y
        {3'd4, 6'd12}: ascii = 8'h5A; // Z
        {3'd4, 6'd13}: ascii = 8'h51; // Q
`ifdef MORSE_DIGITS_EN
        {3'd5, 6'd31}: ascii = 8'h30;
        {3'd5, 6'd15}: ascii = 8'h31;
        {3'd5, 6'd7}:  ascii = 8'h32;
        {3'd5, 6'd3}:  ascii = 8'h33;
        {3'd5, 6'd1}:  ascii = 8'h34;
        {3'd5, 6'd0}:  ascii = 8'h35;
        {3'd5, 6'd16}: ascii = 8'h36;
        {3'd5, 6'd24}: ascii = 8'h37;
        {3'd5, 6'd28}: ascii = 8'h38;
        {3'd5, 6'd30}: ascii = 8'h39;
        {3'd6, 6'd21}: ascii = 8'h2E; // .-.-.-
        {3'd6, 6'd51}: ascii = 8'h2C; // --..--
        {3'd6, 6'd12}: ascii = 8'h3F; // ..--..
`endif
        default:       ascii = ASCII_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/morse_to_ascii.sv
// Accumulates dot/dash pulses, translates each closed character and queues it
// in a small FIFO; word gaps add one space. MORSE_DIGITS_EN enables digit decode.
module morse_to_ascii
  import morse_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int MAX_SYMBOLS = 6
) (
  input  logic             clk,
  input  logic             reset,
  morse_to_ascii_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  morse_state_e            state_q, state_d;
  logic [MORSE_LEN_W-1:0]  len_q, len_d;
  logic [MAX_SYMBOLS-1:0]  pat_q, pat_d;
  logic                    word_open_q, word_open_d;
  logic                    overflow_q, overflow_d;
  logic [AW:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]             rd_ptr_q, rd_ptr_d;
  logic [7:0]              mem_q [DEPTH];

  logic                    sym;
  logic [MORSE_LEN_W-1:0]  eff_len;
  logic [MAX_SYMBOLS-1:0]  eff_pat;
  morse_key_t              key;
  logic [7:0]              char_code;
  logic                    push;
  logic [7:0]              push_data;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    we;

  morse_lut #(
    .MAX_SYMBOLS (MAX_SYMBOLS)
  ) u_lut (
    .key   (key),
    .ascii (char_code)
  );

  // A symbol coinciding with a gap belongs to the character being closed
  always_comb begin
    sym     = bus.dot | bus.dash;
    eff_len = sym ? len_inc(len_q) : len_q;
    eff_pat = sym ? MAX_SYMBOLS'({pat_q, bus.dash}) : pat_q;
    key.len = eff_len;
    key.pat = MORSE_PAT_W'(eff_pat);
  end

  always_comb begin
    state_d     = state_q;
    len_d       = eff_len;
    pat_d       = eff_pat;
    word_open_d = word_open_q;
    push        = 1'b0;
    push_data   = char_code;
    case (state_q)
      ACCUM: begin
        if ((bus.lg | bus.wg) && eff_len != '0) begin
          push        = 1'b1;
          len_d       = '0;
          pat_d       = '0;
          word_open_d = 1'b1;
          if (bus.wg) state_d = SPACE;
        end else if (bus.wg && word_open_q) begin
          state_d = SPACE;
        end
      end
      SPACE: begin
        push        = 1'b1;
        push_data   = ASCII_SPACE;
        word_open_d = 1'b0;
        state_d     = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Pointers carry one extra wrap bit to tell full from empty
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = ~empty & bus.ascii_ready;
    we         = push & (~full | pop);
    wr_ptr_d   = wr_ptr_q + (AW+1)'(we);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    overflow_d = overflow_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      len_q       <= '0;
      pat_q       <= '0;
      word_open_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      word_open_q <= word_open_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign bus.ascii       = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.ascii_valid = ~empty;
  assign bus.overflow    = overflow_q;

endmodule

// File: doc/morse_to_ascii.md
# morse_to_ascii

Consumes the single-cycle `dot`, `dash`, `lg` (letter gap) and `wg` (word gap) pulses produced by the Morse pulse decoder. Accumulates the dot/dash pattern of one character and translates it to 8-bit ASCII at each gap. Buffers the characters in a small output FIFO drained through a valid/ready handshake by the downstream sink (UART TX or display driver). A word gap also emits an ASCII space.

## Interface
- `DEPTH`, 8: output FIFO depth in characters; power of two, at least 2.
- `MAX_SYMBOLS`, 6: longest legal pattern; longer patterns decode to `?`.
- `clk`  in  1  system clock; one clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `dot`  in  1  one-cycle pulse: append a dot.
- `dash`  in  1  one-cycle pulse: append a dash.
- `lg`  in  1  one-cycle pulse: close the current character.
- `wg`  in  1  one-cycle pulse: close the current character, then end the word.
- `ascii`  out  8  head-of-FIFO character.
- `ascii_valid`  out  1  FIFO not empty.
- `ascii_ready`  in  1  sink accepts `ascii` when it is high with `ascii_valid`.
- `overflow`  out  1  sticky; set when a push is dropped because the FIFO is full.

## Operation
- Accumulator holds `len` (0..7, saturating at 7) and `pat[MAX_SYMBOLS-1:0]`.
- Each symbol: `pat <= {pat, dash}` (dot=0, dash=1); `len++`.
- `dot` and `dash` in the same cycle is illegal. `dash` wins.
- Lookup key is `{len, pat}`. It drives the combinational sub-module `morse_lut`, whose output is the 8-bit ASCII code.
- Letters A–Z are output as uppercase 0x41–0x5A.
- A pattern that is not in the table, or that has `len > MAX_SYMBOLS`, produces `?` (0x3F).
- A symbol arriving in the same cycle as `lg` or `wg` is included in the character being closed.
- `lg` and `wg` in the same cycle are treated as `wg`.
- FSM states:
  - ACCUM (reset state). On `lg` with `len>0`: push char, clear the accumulator, stay in ACCUM. On `lg` with `len==0`: no action. On `wg` with `len>0`: push char, clear the accumulator, go to SPACE. On `wg` with `len==0`: go to SPACE only if `word_open` is set, with no push.
  - SPACE: push 0x20, clear `word_open`, return to ACCUM. Symbols that arrive in this cycle are accumulated normally. `lg`/`wg` are ignored.
- `word_open` is set by every character push and cleared by a space push. Consecutive `wg` pulses therefore give at most one space.
- FIFO behaviour:
  - Push when not full: data is written.
  - Push when full: data is dropped and `overflow` is set.
  - Pop on `ascii_valid & ascii_ready`.
  - Simultaneous push and pop when full: the push succeeds.
  - Simultaneous push and pop when empty: the push is written and nothing is popped.
- Reset clears: the accumulator, `word_open`, the FIFO pointers and `overflow`. The FSM returns to ACCUM. Reset in mid-character discards the partial pattern.

## Timing
- Reset values: `ascii_valid=0`, `overflow=0`. `ascii` is don't-care while `ascii_valid=0`, but the implementation drives 0x00.
- Latency:
  - `lg` in cycle n: the character is written at the end of cycle n. It appears on `ascii`/`ascii_valid` in cycle n+1 if the FIFO was empty.
  - `wg` in cycle n: the character is written at the end of n and the space at the end of n+1.
- `ascii` is stable while `ascii_valid=1` and `ascii_ready=0`.
- Throughput: one pop per cycle.
- `overflow` rises in the cycle after the dropped push.

## Configuration
- Macro: `MORSE_DIGITS_EN`.
- When defined, `morse_lut` also decodes the five-symbol digits 0–9 (0x30–0x39) and `.` `,` `?` (six symbols).
- When undefined, these patterns decode to `?` (0x3F). This saves LUT area when only letters are used.

## Structure
- Package `morse_pkg` holds:
  - `MORSE_LEN_W` = 3.
  - `ASCII_SPACE` = 8'h20.
  - `ASCII_UNKNOWN` = 8'h3F.
  - The FSM state enum `{ACCUM, SPACE}`.
  - The `morse_key_t` struct `{len, pat}`.
- Sub-module `morse_lut`: purely combinational, maps `morse_key_t` to 8-bit ASCII, and holds the `MORSE_DIGITS_EN` guard.
- The FIFO is inline: a register array with `$clog2(DEPTH)+1`-bit pointers.

## Test plan
- `dot`, `dash`, `lg`, with `ascii_ready=1` → single 0x41 (`A`) one cycle after `lg`; `ascii_valid` then falls.
- `dash`, `dot`, `dot`, `dot`, `wg` → 0x42 then 0x20 on consecutive cycles. A second `wg` with no symbols gives no further output.
- Seven `dot`, then `lg` → 0x3F. The next character `dash`, `lg` → 0x54 (`T`), showing the accumulator was cleared.
- `ascii_ready=0`; nine `dot`, `lg` groups with DEPTH=8 → `overflow=1` after the 9th. Draining yields exactly eight 0x45.
- Five `dash`, `lg` → 0x30 with `MORSE_DIGITS_EN`, and 0x3F without it.
- `dash`, `dash`, reset, `dot`, `lg` → only 0x45. `lg` or `wg` with an empty accumulator after reset → no output.
